// File: rtl/riscv_pkg.sv
// Shared RV32 pipeline types: fetch packet layout and canonical NOP encoding.
// Included by the fetch/decode boundary logic.
package riscv_pkg;

    localparam int RV_XLEN = 32;

    localparam logic [RV_XLEN-1:0] NOP_INS = 32'h00000013;

    // One queue entry: pc, instruction and the predictor decision, stored as a single word.
    typedef struct packed {
        logic [RV_XLEN-1:0] pc;
        logic [RV_XLEN-1:0] ins;
        logic               pred;
    } fetch_pkt_t;

endpackage

// File: rtl/if_id_queue_mem.sv
// Packet storage for the fetch queue: one write port, asynchronous read, no reset.
// Latency: write visible on the read port the cycle after the write edge; no backpressure of its own.
module if_id_queue_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 65
) (
    input  logic                     i_clk,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]         i_wr_dat,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic [WIDTH-1:0]         o_rd_dat
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem[i_wr_addr] <= i_wr_dat;
        end
    end

    assign o_rd_dat = mem[i_rd_addr];

endmodule

// File: rtl/if_id_queue.sv
// Fetch-to-decode packet queue; 1-cycle latency (0 with IF_ID_QUEUE_BYPASS_EN when empty).
// Backpressure: o_stall from registered occupancy only; i_flush discards everything buffered.
module if_id_queue
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = RV_XLEN
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_valid,
    input  logic [XLEN-1:0]        i_pc,
    input  logic [XLEN-1:0]        i_ins,
    input  logic                   i_pred,
    output logic                   o_stall,
    input  logic                   i_flush,
    output logic                   o_valid,
    output logic [XLEN-1:0]        o_pc,
    output logic [XLEN-1:0]        o_ins,
    output logic                   o_pred,
    input  logic                   i_ready,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;

    logic mem_vld;
    logic byp_vld;
    logic byp_take;
    logic wr_en;
    logic rd_adv;

    fetch_pkt_t in_pkt;
    fetch_pkt_t rd_pkt;
    fetch_pkt_t head_pkt;

    always_comb begin
        in_pkt      = '0;
        in_pkt.pc   = i_pc;
        in_pkt.ins  = i_ins;
        in_pkt.pred = i_pred;
    end

    if_id_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_pkt_t))
    ) u_mem (
        .i_clk     (i_clk),
        .i_wr_en   (wr_en),
        .i_wr_addr (wr_ptr),
        .i_wr_dat  (in_pkt),
        .i_rd_addr (rd_ptr),
        .o_rd_dat  (rd_pkt)
    );

    assign mem_vld = (count != '0);
    assign o_stall = (count == CW'(DEPTH));

`ifdef IF_ID_QUEUE_BYPASS_EN
    // Empty queue forwards the fetch packet straight to decode; if decode takes it, it is never stored.
    assign byp_vld  = ~mem_vld & i_valid & ~i_flush;
    assign byp_take = byp_vld & i_ready;
`else
    assign byp_vld  = 1'b0;
    assign byp_take = 1'b0;
`endif

    assign wr_en     = i_valid & ~o_stall & ~i_flush & ~byp_take;
    assign rd_adv    = mem_vld & i_ready & ~i_flush;
    assign count_nxt = count + CW'(wr_en) - CW'(rd_adv);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            count <= count_nxt;
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_adv) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign head_pkt = byp_vld ? in_pkt : rd_pkt;
    assign o_valid  = mem_vld | byp_vld;
    assign o_count  = count;

    // Storage is never reset, so the head fields are masked whenever nothing valid is presented.
    always_comb begin
        o_pc   = '0;
        o_ins  = NOP_INS;
        o_pred = 1'b0;
        if (o_valid) begin
            o_pc   = head_pkt.pc;
            o_ins  = head_pkt.ins;
            o_pred = head_pkt.pred;
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed vector table plus randomized run against a queue-based reference model.
module tb_if_id_queue;

    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h00000013;
`ifdef IF_ID_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic [31:0] i_pc = '0;
    logic [31:0] i_ins = '0;
    logic        i_pred = 1'b0;
    logic        i_flush = 1'b0;
    logic        i_ready = 1'b0;
    logic        o_stall;
    logic        o_valid;
    logic [31:0] o_pc;
    logic [31:0] o_ins;
    logic        o_pred;
    logic [2:0]  o_count;

    int tests = 0;
    int fails = 0;

    if_id_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .i_pc    (i_pc),
        .i_ins   (i_ins),
        .i_pred  (i_pred),
        .o_stall (o_stall),
        .i_flush (i_flush),
        .o_valid (o_valid),
        .o_pc    (o_pc),
        .o_ins   (o_ins),
        .o_pred  (o_pred),
        .i_ready (i_ready),
        .o_count (o_count)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        bit          rst;
        bit          vld;
        logic [31:0] pc;
        bit          pred;
        bit          rdy;
        bit          flush;
        bit          chk;
        bit          e_vld;
        logic [31:0] e_pc;
        bit          e_pred;
        int          e_cnt;
        bit          e_stall;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        pred;
    } pkt_t;

    vec_t vecs[$];
    pkt_t mq[$];

    function automatic logic [31:0] ins_of(logic [31:0] pc);
        return pc ^ 32'hC0DE0000;
    endfunction

    function automatic void add(bit rst, bit vld, logic [31:0] pc, bit pred, bit rdy, bit flush,
                                bit chk, bit e_vld, logic [31:0] e_pc, bit e_pred, int e_cnt, bit e_stall);
        vec_t v;
        v.rst = rst; v.vld = vld; v.pc = pc; v.pred = pred; v.rdy = rdy; v.flush = flush;
        v.chk = chk; v.e_vld = e_vld; v.e_pc = e_pc; v.e_pred = e_pred; v.e_cnt = e_cnt;
        v.e_stall = e_stall;
        vecs.push_back(v);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(bit rst, bit vld, logic [31:0] pc, logic [31:0] ins, bit pred, bit rdy, bit flush);
        i_rst = rst; i_valid = vld; i_pc = pc; i_ins = ins; i_pred = pred;
        i_ready = rdy; i_flush = flush;
    endtask

    task automatic check_outputs(string tag, bit e_vld, logic [31:0] e_pc, logic [31:0] e_ins,
                                 bit e_pred, int e_cnt, bit e_stall);
        chk({tag, ".valid"}, 32'(o_valid), 32'(e_vld));
        chk({tag, ".pc"},    o_pc,         e_pc);
        chk({tag, ".ins"},   o_ins,        e_ins);
        chk({tag, ".pred"},  32'(o_pred),  32'(e_pred));
        chk({tag, ".count"}, 32'(o_count), 32'(e_cnt));
        chk({tag, ".stall"}, 32'(o_stall), 32'(e_stall));
    endtask

    initial begin
        // reset held two cycles, then idle
        add(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
        // fill, offer a 5th while full, then drain
        add(0, 1, 32'h00, 0, 0, 0,  1, 0, 0,     0, 0, 0);
        add(0, 1, 32'h04, 1, 0, 0,  1, 1, 32'h00, 0, 1, 0);
        add(0, 1, 32'h08, 0, 0, 0,  1, 1, 32'h00, 0, 2, 0);
        add(0, 1, 32'h0C, 1, 0, 0,  1, 1, 32'h00, 0, 3, 0);
        add(0, 1, 32'h10, 0, 0, 0,  1, 1, 32'h00, 0, 4, 1);
        add(0, 0, 0,      0, 1, 0,  1, 1, 32'h00, 0, 4, 1);
        add(0, 0, 0,      0, 1, 0,  1, 1, 32'h04, 1, 3, 0);
        add(0, 0, 0,      0, 1, 0,  1, 1, 32'h08, 0, 2, 0);
        add(0, 0, 0,      0, 1, 0,  1, 1, 32'h0C, 1, 1, 0);
        add(0, 0, 0,      0, 1, 0,  1, 0, 0,      0, 0, 0);
        // steady stream: output trails input by one cycle, occupancy 1
        for (int k = 0; k < 10; k++) begin
            if (k == 0) add(0, 1, 32'h100, 0, 1, 0,  1, 0, 0, 0, 0, 0);
            else        add(0, 1, 32'h100 + 4*k, 0, 1, 0,  1, 1, 32'h100 + 4*(k-1), 0, 1, 0);
        end
        add(0, 0, 0, 0, 1, 0,  1, 1, 32'h124, 0, 1, 0);
        add(0, 0, 0, 0, 1, 0,  1, 0, 0,       0, 0, 0);
        // wrap-around: push 3, pop 3, push 4 with pred 1,0,1,0, pop 4
        add(0, 1, 32'h300, 0, 0, 0,  1, 0, 0,       0, 0, 0);
        add(0, 1, 32'h304, 0, 0, 0,  1, 1, 32'h300, 0, 1, 0);
        add(0, 1, 32'h308, 0, 0, 0,  1, 1, 32'h300, 0, 2, 0);
        add(0, 0, 0,       0, 1, 0,  1, 1, 32'h300, 0, 3, 0);
        add(0, 0, 0,       0, 1, 0,  1, 1, 32'h304, 0, 2, 0);
        add(0, 0, 0,       0, 1, 0,  1, 1, 32'h308, 0, 1, 0);
        add(0, 1, 32'h400, 1, 0, 0,  1, 0, 0,       0, 0, 0);
        add(0, 1, 32'h404, 0, 0, 0,  1, 1, 32'h400, 1, 1, 0);
        add(0, 1, 32'h408, 1, 0, 0,  1, 1, 32'h400, 1, 2, 0);
        add(0, 1, 32'h40C, 0, 0, 0,  1, 1, 32'h400, 1, 3, 0);
        add(0, 0, 0,       0, 1, 0,  1, 1, 32'h400, 1, 4, 1);
        add(0, 0, 0,       0, 1, 0,  1, 1, 32'h404, 0, 3, 0);
        add(0, 0, 0,       0, 1, 0,  1, 1, 32'h408, 1, 2, 0);
        add(0, 0, 0,       0, 1, 0,  1, 1, 32'h40C, 0, 1, 0);
        add(0, 0, 0,       0, 1, 0,  1, 0, 0,       0, 0, 0);
        // flush with a concurrent push: 0x200 must never surface
        add(0, 1, 32'h500, 0, 0, 0,  1, 0, 0,       0, 0, 0);
        add(0, 1, 32'h504, 0, 0, 0,  1, 1, 32'h500, 0, 1, 0);
        add(0, 1, 32'h200, 1, 0, 1,  1, 1, 32'h500, 0, 2, 0);
        add(0, 0, 0,       0, 1, 0,  1, 0, 0,       0, 0, 0);
        add(0, 0, 0,       0, 1, 0,  1, 0, 0,       0, 0, 0);
        // reset mid-operation with push and pop requested
        add(0, 1, 32'h600, 1, 0, 0,  1, 0, 0,       0, 0, 0);
        add(0, 1, 32'h604, 0, 0, 0,  1, 1, 32'h600, 1, 1, 0);
        add(0, 1, 32'h608, 0, 0, 0,  1, 1, 32'h600, 1, 2, 0);
        add(1, 1, 32'h60C, 1, 1, 0,  1, 1, 32'h600, 1, 3, 0);
        add(0, 0, 0,       0, 0, 0,  1, 0, 0,       0, 0, 0);

        if (!BYP) begin
            for (int i = 0; i < vecs.size(); i++) begin
                @(negedge i_clk);
                drive(vecs[i].rst, vecs[i].vld, vecs[i].pc, ins_of(vecs[i].pc), vecs[i].pred,
                      vecs[i].rdy, vecs[i].flush);
                #1;
                if (vecs[i].chk) begin
                    check_outputs($sformatf("vec%0d", i), vecs[i].e_vld, vecs[i].e_pc,
                                  vecs[i].e_vld ? ins_of(vecs[i].e_pc) : NOP,
                                  vecs[i].e_pred, vecs[i].e_cnt, vecs[i].e_stall);
                end
            end
        end else begin
            // bypass: empty queue shows the incoming packet in the same cycle
            @(negedge i_clk); drive(1, 0, 0, 0, 0, 0, 0);
            @(negedge i_clk); drive(0, 1, 32'h40, ins_of(32'h40), 1, 0, 0);
            #1;
            check_outputs("byp_same_cycle", 1, 32'h40, ins_of(32'h40), 1, 0, 0);
            @(negedge i_clk); drive(0, 0, 0, 0, 0, 1, 0);
            #1;
            check_outputs("byp_stored", 1, 32'h40, ins_of(32'h40), 1, 1, 0);
            @(negedge i_clk); drive(0, 1, 32'h44, ins_of(32'h44), 0, 1, 0);
            #1;
            check_outputs("byp_consumed", 1, 32'h44, ins_of(32'h44), 0, 0, 0);
            @(negedge i_clk); drive(0, 0, 0, 0, 0, 0, 0);
            #1;
            check_outputs("byp_not_written", 0, 0, NOP, 0, 0, 0);
        end

        // randomized run against the reference queue
        @(negedge i_clk); drive(1, 0, 0, 0, 0, 0, 0);
        mq.delete();
        for (int c = 0; c < 3000; c++) begin
            bit          r_rst, r_vld, r_rdy, r_flush, r_pred, e_vld, e_stall, took, sz0;
            logic [31:0] r_pc, r_ins;
            pkt_t        e;
            @(negedge i_clk);
            r_rst   = ($urandom_range(0, 99) == 0);
            r_flush = ($urandom_range(0, 39) == 0);
            r_vld   = ($urandom_range(0, 99) < 65);
            r_rdy   = ($urandom_range(0, 99) < ((c / 500) % 2 == 0 ? 70 : 30));
            r_pc    = $urandom;
            r_ins   = $urandom;
            r_pred  = 1'($urandom);
            drive(r_rst, r_vld, r_pc, r_ins, r_pred, r_rdy, r_flush);
            #1;
            e_stall = (mq.size() == DEPTH);
            e_vld   = 1'b1;
            if (mq.size() > 0) begin
                e = mq[0];
            end else if (BYP && r_vld && !r_flush) begin
                e.pc = r_pc; e.ins = r_ins; e.pred = r_pred;
            end else begin
                e_vld = 1'b0; e.pc = '0; e.ins = NOP; e.pred = 1'b0;
            end
            check_outputs($sformatf("rnd%0d", c), e_vld, e.pc, e.ins, e.pred, mq.size(), e_stall);

            if (r_rst || r_flush) begin
                mq.delete();
            end else begin
                sz0  = (mq.size() == 0);
                took = r_vld && !e_stall;
                if (!sz0 && r_rdy) begin
                    void'(mq.pop_front());
                end else if (sz0 && BYP && r_vld && r_rdy) begin
                    took = 1'b0;
                end
                if (took) begin
                    pkt_t p;
                    p.pc = r_pc; p.ins = r_ins; p.pred = r_pred;
                    mq.push_back(p);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
